// File: rtl/reg_readback_pkg.sv
// Shared types and sizing helpers for the capture-register readback serializer.
package reg_readback_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam int WIDTH_DEF  = 4;
   localparam int NBANKS_DEF = 3;

   // Frame length: every bank bit plus one trailing even-parity bit.
   function automatic int frame_bits(input int width, input int nbanks);
      return width * nbanks + 1;
   endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in, serial-out shift register. Load wins over shift; shifts left
// with zero fill and presents the MSB as the serial bit.
module piso_shreg #(
   parameter int W = 12
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         msb
);

   logic [W-1:0] shreg;

   // Snapshot on load, otherwise advance one bit per accepted transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg <= '0;
      end else if (load) begin
         shreg <= din;
      end else if (shift) begin
         shreg <= {shreg[W-2:0], 1'b0};
      end
   end

   assign msb = shreg[W-1];

endmodule

// File: rtl/reg_readback_serializer.sv
// Snapshots the three capture-register banks on start and streams them
// MSB-first (Q1, Q2, Q3) over a valid/ready 1-bit link, followed by an
// even-parity bit flagged with sdo_last.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; stream outputs low
//   SHIFT | presenting bit cnt; advances only when sdo_ready is high
//   DONE  | one-cycle done pulse after the parity bit was accepted
module reg_readback_serializer
   import reg_readback_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int NBANKS = NBANKS_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] q1_in,
   input  logic [WIDTH-1:0] q2_in,
   input  logic [WIDTH-1:0] q3_in,
   output logic             sdo,
   output logic             sdo_valid,
   input  logic             sdo_ready,
   output logic             sdo_last,
   output logic             busy,
   output logic             done
);

   localparam int FRAME_BITS = frame_bits(WIDTH, NBANKS);
   localparam int DATA_W     = WIDTH * NBANKS;
   localparam int CNT_W      = $clog2(FRAME_BITS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               par;
   logic               data_msb;
   logic [DATA_W-1:0]  snap;
   logic               load;
   logic               xfer;
   logic               shift;

   // The port list fixes the bank order; NBANKS is expected to stay at 3.
   assign snap  = {q1_in, q2_in, q3_in};
   assign load  = (state == IDLE) && start;
   assign xfer  = (state == SHIFT) && sdo_ready;
   assign shift = xfer && !sdo_last;

   piso_shreg #(.W(DATA_W)) u_piso_shreg (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .shift (shift),
      .din   (snap),
      .msb   (data_msb)
   );

   // Frame sequencing with registered handshake/status outputs; parity is
   // computed from the same snapshot the shift register loads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         par       <= 1'b0;
         sdo_valid <= 1'b0;
         sdo_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  par       <= ^snap;
                  cnt       <= '0;
                  sdo_valid <= 1'b1;
                  sdo_last  <= 1'b0;
                  busy      <= 1'b1;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               if (sdo_ready) begin
                  if (cnt == LAST_CNT) begin
                     sdo_valid <= 1'b0;
                     sdo_last  <= 1'b0;
                     done      <= 1'b1;
                     state     <= DONE;
                  end else begin
                     cnt      <= cnt + CNT_W'(1);
                     sdo_last <= ((cnt + CNT_W'(1)) == LAST_CNT);
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               sdo_valid <= 1'b0;
               sdo_last  <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   // Parity replaces the data bit on the final beat; low whenever not valid.
   assign sdo = sdo_valid & (sdo_last ? par : data_msb);

endmodule

// File: tb/tb_reg_readback_serializer.sv
// Scoreboard bench for reg_readback_serializer: stimulus pushes hand-computed
// frames, a negedge monitor pops and compares on every accepted transfer.
module tb_reg_readback_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] q1, q2, q3;
   logic       sdo, sdo_valid, sdo_ready, sdo_last, busy, done;

   typedef struct {
      logic b;
      logic last;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;
   int   done_cnt = 0;

   logic stall_q, stall_sdo, stall_last, pend_done;
   int   xfer;

   reg_readback_serializer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .q1_in     (q1),
      .q2_in     (q2),
      .q3_in     (q3),
      .sdo       (sdo),
      .sdo_valid (sdo_valid),
      .sdo_ready (sdo_ready),
      .sdo_last  (sdo_last),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Frame constant is MSB-first: bit 12 goes out first, bit 0 is parity.
   task automatic push_frame(input logic [12:0] frame);
      exp_t e;
      for (int i = 12; i >= 0; i--) begin
         e.b    = frame[i];
         e.last = (i == 0);
         sb.push_back(e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < 100 && done_cnt == d0; i++) tick();
      check(name, done_cnt - d0, 1);
   endtask

   // Monitor: compares every accepted bit, hold-under-backpressure, done timing
   // and frame length.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         stall_q   = 1'b0;
         pend_done = 1'b0;
         xfer      = 0;
      end else begin
         if (done || pend_done) check("done_timing", int'(done), int'(pend_done));
         if (done) begin
            done_cnt++;
            check("frame_len", xfer, 13);
            xfer = 0;
         end
         if (stall_q) begin
            check("valid_held", int'(sdo_valid), 1);
            check("hold_sdo", int'(sdo), int'(stall_sdo));
            check("hold_last", int'(sdo_last), int'(stall_last));
         end
         pend_done = 1'b0;
         stall_q   = 1'b0;
         if (sdo_valid && sdo_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_bit", 1, 0);
            end else begin
               e = sb.pop_front();
               check("sdo_bit", int'(sdo), int'(e.b));
               check("sdo_last", int'(sdo_last), int'(e.last));
            end
            xfer++;
            pend_done = sdo_last;
         end else if (sdo_valid) begin
            stall_q    = 1'b1;
            stall_sdo  = sdo;
            stall_last = sdo_last;
         end
      end
   end

   initial begin
      logic [3:0] pat;
      int d0;
      rst = 1'b0; start = 1'b0; sdo_ready = 1'b1;
      q1 = '0; q2 = '0; q3 = '0;
      tick(); tick();
      check("rst_valid", int'(sdo_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_sdo", int'(sdo), 0);
      check("rst_last", int'(sdo_last), 0);
      rst = 1'b1;
      tick();

      // Basic frame A,5,F: 8 ones -> parity 0.
      q1 = 4'hA; q2 = 4'h5; q3 = 4'hF;
      push_frame(13'b1010_0101_1111_0);
      check("idle_valid", int'(sdo_valid), 0);
      pulse_start();
      check("first_bit_latency", int'(sdo_valid), 1);
      check("busy_in_frame", int'(busy), 1);
      repeat (12) tick();
      check("parity_beat_last", int'(sdo_last), 1);
      check("no_early_done", int'(done), 0);
      tick();
      check("done_pulse", int'(done), 1);
      check("done_busy", int'(busy), 1);
      check("done_valid_low", int'(sdo_valid), 0);
      tick();
      check("done_one_cycle", int'(done), 0);
      check("idle_after_done", int'(busy), 0);
      check("sb_empty_basic", sb.size(), 0);

      // Backpressure: 1,0,0 -> single one, parity 1; ready pattern 1,0,0,1.
      q1 = 4'h1; q2 = 4'h0; q3 = 4'h0;
      push_frame(13'b0001_0000_0000_1);
      pat = 4'b1001;
      pulse_start();
      d0 = done_cnt;
      for (int i = 0; i < 200 && done_cnt == d0; i++) begin
         sdo_ready = pat[3 - (i % 4)];
         tick();
      end
      check("bp_done", done_cnt - d0, 1);
      sdo_ready = 1'b1;
      tick();
      check("sb_empty_bp", sb.size(), 0);

      // Snapshot isolation (3,3,3 -> parity 0) plus start while busy at bit 5.
      q1 = 4'h3; q2 = 4'h3; q3 = 4'h3;
      push_frame(13'b0011_0011_0011_0);
      pulse_start();
      q1 = 4'hC; q2 = 4'hC; q3 = 4'hC;
      repeat (4) tick();
      pulse_start();
      wait_done("busy_frame_done");
      d0 = done_cnt;
      repeat (20) tick();
      check("no_second_frame", done_cnt, d0);
      check("idle_after_busy_start", int'(busy), 0);
      check("sb_empty_snap", sb.size(), 0);

      // Async reset mid-frame at bit 7 (a one in the A,5,F stream).
      q1 = 4'hA; q2 = 4'h5; q3 = 4'hF;
      push_frame(13'b1010_0101_1111_0);
      pulse_start();
      repeat (7) tick();
      check("pre_reset_sdo", int'(sdo), 1);
      #2 rst = 1'b0;
      #1;
      check("async_valid", int'(sdo_valid), 0);
      check("async_busy", int'(busy), 0);
      check("async_sdo", int'(sdo), 0);
      check("async_done", int'(done), 0);
      sb.delete();
      d0 = done_cnt;
      tick(); tick();
      rst = 1'b1;
      repeat (3) tick();
      check("no_done_after_reset", done_cnt, d0);
      check("idle_after_reset", int'(busy), 0);

      // All-ones frame after reset: 12 ones -> parity 0.
      q1 = 4'hF; q2 = 4'hF; q3 = 4'hF;
      push_frame(13'b1111_1111_1111_0);
      pulse_start();
      wait_done("post_reset_done");
      tick();
      check("sb_empty_final", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/reg_readback_serializer.md
Name: reg_readback_serializer

Overview:
Reader-side companion to the three-bank 4-bit capture register (Q1/Q2/Q3 outputs).
- On request, snapshots all three banks and serialises them MSB-first onto a 1-bit stream with a valid/ready handshake.
- Appends one even-parity bit to each frame.
- Sits between the capture register outputs and the DCDR test/observation path, so register contents can be read over a single wire without widening the observation bus.

Parameters:
- WIDTH, 4, bit width of each captured bank.
- NBANKS, 3, number of banks serialised per frame (fixed order Q1, Q2, Q3).
- FRAME_BITS, WIDTH*NBANKS+1, total bits per frame including the parity bit (derived; not overridable).

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to snapshot the banks and begin a frame.
- q1_in  input  WIDTH  bank 1 value (from Q1).
- q2_in  input  WIDTH  bank 2 value (from Q2).
- q3_in  input  WIDTH  bank 3 value (from Q3).
- sdo  output  1  serial data bit.
- sdo_valid  output  1  sdo holds a valid bit.
- sdo_ready  input  1  sink accepts the current bit this cycle.
- sdo_last  output  1  current bit is the parity bit (last of frame).
- busy  output  1  frame in progress (state != IDLE).
- done  output  1  one-cycle pulse after the last bit is accepted.

Behaviour:
Reset:
- rst low forces state IDLE and zeroes the shift register, bit counter and parity, immediately and independently of clk.
- All outputs are 0 during reset.
- Reset mid-frame abandons the frame. No done pulse is issued. After release the block is in IDLE.

States: IDLE, SHIFT, DONE.

IDLE:
- sdo_valid=0, busy=0, sdo=0.
- start=1 at a rising edge:
  - load shreg = {q1_in, q2_in, q3_in} (q1_in[WIDTH-1] is the first bit out);
  - load par = XOR of all 12 snapshot bits;
  - cnt=0;
  - go to SHIFT.
- First bit is valid the cycle after start (latency 1).
- Input changes after the snapshot edge do not affect the frame.

SHIFT:
- sdo_valid=1, busy=1.
- For cnt < FRAME_BITS-1: sdo = shreg MSB. For cnt == FRAME_BITS-1: sdo = par and sdo_last=1.
- Transfer happens on an edge where sdo_valid & sdo_ready.
  - If not last: shreg shifts left by 1 (zero fill) and cnt++.
  - If last: go to DONE.
- sdo_ready=0 holds sdo, sdo_last and cnt stable for any number of cycles.
- sdo_valid never drops mid-frame.

DONE:
- done=1, busy=1, sdo_valid=0 for exactly one cycle, then IDLE.

Handshake and width rules:
- start is ignored in SHIFT and DONE. It is not queued.
- Back-to-back frames: start asserted in the cycle after DONE is accepted, giving a minimum 1 idle cycle between frames.
- cnt is ceil(log2(FRAME_BITS)) bits, i.e. 4 bits for defaults. cnt never exceeds FRAME_BITS-1, so there is no wrap.
- Parity is even: total ones in the 13-bit frame is even.

Decomposition:
- Shared package `reg_readback_pkg`:
  - state enum {IDLE, SHIFT, DONE};
  - WIDTH_DEF, NBANKS_DEF;
  - FRAME_BITS function.
- One natural sub-module, `piso_shreg`:
  - parallel-load, shift-left-on-enable register with MSB output;
  - parameterised by width;
  - same async active-low rst.
- FSM, counter and parity stay in the top module.

Test Plan:
- Basic frame: rst released; q1=4'hA, q2=4'h5, q3=4'hF; start pulse; sdo_ready=1 constantly.
  - Expect sdo = 1,0,1,0, 0,1,0,1, 1,1,1,1, 0 on 13 consecutive cycles starting 1 cycle after start.
  - sdo_last only on the 13th bit.
  - done pulse on cycle start+14; busy low afterwards.
- Backpressure: q1=4'h1, q2=4'h0, q3=4'h0; sdo_ready toggled 1,0,0,1,…
  - Bits 0,0,0,1,0…0 then parity 1.
  - Each bit is held while ready=0.
  - Frame length equals 13 accepted transfers.
- Snapshot isolation: start with q1=q2=q3=4'h3, then change all inputs to 4'hC on the next cycle.
  - Stream is 0011 0011 0011 + parity 0, unaffected by the change.
- Start while busy: second start pulse at bit 5.
  - Ignored: no restart, exactly one done pulse, and no second frame without a new start in IDLE.
- Async reset mid-frame: drive rst low at bit 7, between clock edges.
  - sdo_valid, busy and sdo go 0 immediately; no done pulse.
  - After release, a new start with q=4'hF,4'hF,4'hF gives all-ones then parity 0.
